z80_run_ctrl: RTL and testbench
===============================

# z80_run_ctrl

Parametrised run controller for the Z80 simulation and FPGA harness. It sequences CPU reset and generates periodic interrupt stimulus on NUM_SRC channels, each in pulse or hold-until-acknowledge mode. It ends a run when the program counter passes a configured limit or a cycle budget expires. It sits between the harness top level and the z80 core, driving its reset and interrupt inputs.

## Interface
- ADDR_W, 16, width of pc and cfg_pc_limit
- CNT_W, 32, width of cycle, period and timeout counters
- NUM_SRC, 2, number of interrupt channels (channel 0 drives INT_L, channel 1 drives NMI_L by convention)
- clk  in  1  system clock, all state updates on its rising edge
- rst_L  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run from IDLE or DONE
- cfg_rst_cycles  in  8  number of cycles cpu_rst_L is held low; 0 is treated as 1
- cfg_pc_limit  in  ADDR_W  run ends when pc > cfg_pc_limit
- cfg_timeout  in  CNT_W  cycle budget; 0 disables the timeout
- cfg_irq_en  in  NUM_SRC  per-channel enable
- cfg_irq_mode  in  NUM_SRC  per channel: 0 = pulse, 1 = hold until irq_ack
- cfg_irq_period  in  NUM_SRC*CNT_W  per-channel firing period in cycles; 0 disables the channel
- cfg_irq_width  in  NUM_SRC*8  pulse-mode low time in cycles; 0 is treated as 1
- pc  in  ADDR_W  current CPU program counter
- irq_ack  in  NUM_SRC  per-channel acknowledge, sampled high
- cpu_rst_L  out  1  CPU reset, active low
- irq_L  out  NUM_SRC  interrupt lines, active low
- running  out  1  high in RUN
- done  out  1  sticky run-complete flag
- timeout  out  1  sticky flag: the run ended by budget, not by pc
- irq_missed  out  NUM_SRC  sticky: the channel fired while its line was already asserted
- cycle_count  out  CNT_W  RUN cycles elapsed, saturating

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, cpu_rst_L 0, irq_L all 1, running 0, done 0, timeout 0, irq_missed 0, cycle_count 0, all counters 0.
- IDLE: cpu_rst_L 0. On start, go to RESET and load the reset counter with max(cfg_rst_cycles, 1).
- RESET: cpu_rst_L 0. The counter decrements each cycle. When it reaches 1, go to RUN. start is ignored in this state.
- RESET entry clears done, timeout, irq_missed, cycle_count and all channel counters.
- RUN: cpu_rst_L 1, running 1, and cycle_count increments each cycle, saturating at all-ones.
- RUN exit conditions, evaluated each cycle:
  - pc > cfg_pc_limit (unsigned): go to DONE, done 1.
  - Otherwise, if cfg_timeout != 0 and cycle_count == cfg_timeout - 1: go to DONE, done 1, timeout 1.
  - If both are true in the same cycle, the pc exit wins and timeout stays 0.
- DONE: cpu_rst_L 0 (CPU frozen), irq_L all 1, running 0. Flags and cycle_count hold. On start, go to RESET.
- start in RUN is ignored.
- Per channel i in RUN, when cfg_irq_en[i] is set and the period is nonzero:
  - The phase counter counts 0 to period-1 and wraps.
  - At period-1 the channel fires.
  - If irq_L[i] is already 0 when the channel fires, set irq_missed[i] and leave the line unchanged.
- Pulse mode: irq_L[i] stays low for max(width, 1) cycles. irq_ack[i] releases it early.
- Hold mode: irq_L[i] stays low until irq_ack[i] is sampled high, and releases on the following edge.
- irq_ack[i] while irq_L[i] is high is ignored.
- A channel that is disabled mid-run releases its line on the next edge, and its phase counter resets to 0.
- Config inputs are expected stable during a run. The period and width values are sampled on each firing.

## Timing
- start high at edge N: at edge N+1 the state is RESET with cpu_rst_L 0.
- cpu_rst_L rises at edge N+1+max(cfg_rst_cycles, 1), which is RUN entry. cycle_count is 1 after the first RUN edge.
- Channel with period P: the first irq_L fall occurs at the P-th RUN edge, with later falls every P cycles.
- Pulse mode with width W: irq_L rises exactly max(W, 1) edges after it falls.
- pc exceeding the limit at edge M: done and running change at edge M+1, and cpu_rst_L falls at M+1.
- The timeout run ends with done at the edge where cycle_count would become cfg_timeout, so exactly cfg_timeout RUN cycles elapse.
- Asynchronous reset at any time, including mid-RUN with a line asserted, immediately forces all reset values. No start is remembered across reset.

## Test plan
- Reset and run: cfg_rst_cycles 3, start at cycle 5, pc ramps past limit 0x0050.
  - cpu_rst_L rises at cycle 9.
  - done rises one cycle after pc = 0x0051.
  - timeout 0 and cpu_rst_L 0 in DONE.
- Pulse interrupt: channel 0 with period 100, width 10, pulse mode.
  - irq_L[0] is low on RUN cycles 100–109 and 200–209.
  - irq_missed 0.
- Hold mode and miss: channel 1 with period 20, hold mode, ack withheld for 50 cycles, then pulsed.
  - irq_L[1] falls at cycle 20.
  - irq_missed[1] sets at cycle 40.
  - Line rises the edge after the ack.
- Timeout and priority:
  - cfg_timeout 1000 with pc static: done and timeout rise, cycle_count is 1000.
  - Rerun with pc crossing the limit on the same cycle as the timeout: done 1, timeout 0.
- Mid-run abort: assert rst_L low during an active pulse.
  - All outputs take reset values immediately.
  - After release, start launches a clean run with cycle_count restarting from 0.

Source files
------------

// File: rtl/z80_run_ctrl.sv
// z80_run_ctrl: run controller for the Z80 harness.
// Sequences CPU reset, drives periodic interrupt stimulus on NUM_SRC channels
// (pulse or hold-until-ack), and ends a run on a pc limit or a cycle budget.
// Ports:
//   clk, rst_L                 clock, async active-low reset
//   start                      one-cycle pulse, begins a run from IDLE/DONE
//   cfg_rst_cycles             cycles of CPU reset (0 behaves as 1)
//   cfg_pc_limit, cfg_timeout  run end conditions (timeout 0 = off)
//   cfg_irq_en/mode/period/width  per-channel interrupt setup
//   pc, irq_ack                CPU program counter, per-channel acknowledge
//   cpu_rst_L, irq_L           CPU reset and interrupt lines (active low)
//   running, done, timeout     run status (done/timeout sticky)
//   irq_missed                 sticky: channel fired while its line was low
//   cycle_count                saturating count of RUN cycles
module z80_run_ctrl #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned NUM_SRC = 2
) (
   input  logic                       clk,
   input  logic                       rst_L,
   input  logic                       start,
   input  logic [7:0]                 cfg_rst_cycles,
   input  logic [ADDR_W-1:0]          cfg_pc_limit,
   input  logic [CNT_W-1:0]           cfg_timeout,
   input  logic [NUM_SRC-1:0]         cfg_irq_en,
   input  logic [NUM_SRC-1:0]         cfg_irq_mode,
   input  logic [NUM_SRC*CNT_W-1:0]   cfg_irq_period,
   input  logic [NUM_SRC*8-1:0]       cfg_irq_width,
   input  logic [ADDR_W-1:0]          pc,
   input  logic [NUM_SRC-1:0]         irq_ack,
   output logic                       cpu_rst_L,
   output logic [NUM_SRC-1:0]         irq_L,
   output logic                       running,
   output logic                       done,
   output logic                       timeout,
   output logic [NUM_SRC-1:0]         irq_missed,
   output logic [CNT_W-1:0]           cycle_count
);

   localparam int unsigned WID_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   state_t                            state_q, state_d;
   logic [7:0]                        rst_cnt_q, rst_cnt_d;
   logic [NUM_SRC-1:0][CNT_W-1:0]     phase_q, phase_d;
   logic [NUM_SRC-1:0][WID_W-1:0]     wcnt_q, wcnt_d;
   logic [NUM_SRC-1:0]                irq_l_q, irq_l_d;
   logic [NUM_SRC-1:0]                missed_q, missed_d;
   logic                              cpu_rst_l_q, cpu_rst_l_d;
   logic                              running_q, running_d;
   logic                              done_q, done_d;
   logic                              timeout_q, timeout_d;
   logic [CNT_W-1:0]                  cycle_q, cycle_d;

   logic [NUM_SRC-1:0]                chan_on_c;
   logic [NUM_SRC-1:0]                fire_c;

   // Per-channel activity and firing strobe; >= keeps a shrunken period from stalling
   always_comb begin
      chan_on_c = '0;
      fire_c    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         chan_on_c[i] = cfg_irq_en[i] && (cfg_irq_period[i*CNT_W +: CNT_W] != '0);
         fire_c[i]    = chan_on_c[i] &&
                        (phase_q[i] >= (cfg_irq_period[i*CNT_W +: CNT_W] - CNT_W'(1)));
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      phase_d     = phase_q;
      wcnt_d      = wcnt_q;
      irq_l_d     = irq_l_q;
      missed_d    = missed_q;
      done_d      = done_q;
      timeout_d   = timeout_q;
      cycle_d     = cycle_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_RESET;
               rst_cnt_d = (cfg_rst_cycles == 8'd0) ? 8'd1 : cfg_rst_cycles;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               missed_d  = '0;
               cycle_d   = '0;
               phase_d   = '0;
               wcnt_d    = '0;
            end
         end

         S_RESET: begin
            if (rst_cnt_q <= 8'd1) state_d = S_RUN;
            else                   rst_cnt_d = rst_cnt_q - 8'(1);
         end

         S_RUN: begin
            if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);

            // pc exit has priority over the budget exit
            if (pc > cfg_pc_limit) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if ((cfg_timeout != '0) && (cycle_q == cfg_timeout - CNT_W'(1))) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end

            for (int i = 0; i < NUM_SRC; i++) begin
               if (!chan_on_c[i]) begin
                  phase_d[i] = '0;
                  wcnt_d[i]  = '0;
                  irq_l_d[i] = 1'b1;
               end else begin
                  phase_d[i] = fire_c[i] ? '0 : phase_q[i] + CNT_W'(1);
                  if (!irq_l_q[i]) begin
                     // Line asserted: ack or pulse expiry releases; a new fire is a miss
                     if (irq_ack[i]) begin
                        irq_l_d[i] = 1'b1;
                     end else if (!cfg_irq_mode[i]) begin
                        if (wcnt_q[i] <= WID_W'(1)) irq_l_d[i] = 1'b1;
                        else                        wcnt_d[i]  = wcnt_q[i] - WID_W'(1);
                     end
                     if (fire_c[i]) missed_d[i] = 1'b1;
                  end else if (fire_c[i]) begin
                     irq_l_d[i] = 1'b0;
                     wcnt_d[i]  = (cfg_irq_width[i*WID_W +: WID_W] == '0) ?
                                  WID_W'(1) : cfg_irq_width[i*WID_W +: WID_W];
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Lines are only driven while running
      if (state_d != S_RUN) irq_l_d = '1;

      running_d   = (state_d == S_RUN);
      cpu_rst_l_d = (state_d == S_RUN);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         phase_q     <= '0;
         wcnt_q      <= '0;
         irq_l_q     <= '1;
         missed_q    <= '0;
         cpu_rst_l_q <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         phase_q     <= phase_d;
         wcnt_q      <= wcnt_d;
         irq_l_q     <= irq_l_d;
         missed_q    <= missed_d;
         cpu_rst_l_q <= cpu_rst_l_d;
         running_q   <= running_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         cycle_q     <= cycle_d;
      end
   end

   assign cpu_rst_L   = cpu_rst_l_q;
   assign irq_L       = irq_l_q;
   assign running     = running_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign irq_missed  = missed_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_z80_run_ctrl.sv
// tb_z80_run_ctrl: scoreboard bench for z80_run_ctrl.
// Stimulus pushes edge-tagged expectations into a sorted queue; a negedge
// monitor pops every expectation due at the current edge and compares.
module tb_z80_run_ctrl;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned NUM_SRC = 2;

   localparam int SIG_CPU_RST = 0;
   localparam int SIG_RUNNING = 1;
   localparam int SIG_DONE    = 2;
   localparam int SIG_TIMEOUT = 3;
   localparam int SIG_IRQ0    = 4;
   localparam int SIG_IRQ1    = 5;
   localparam int SIG_MISSED  = 6;
   localparam int SIG_CYCLE   = 7;

   logic                     clk;
   logic                     rst_L;
   logic                     start;
   logic [7:0]               cfg_rst_cycles;
   logic [ADDR_W-1:0]        cfg_pc_limit;
   logic [CNT_W-1:0]         cfg_timeout;
   logic [NUM_SRC-1:0]       cfg_irq_en;
   logic [NUM_SRC-1:0]       cfg_irq_mode;
   logic [NUM_SRC*CNT_W-1:0] cfg_irq_period;
   logic [NUM_SRC*8-1:0]     cfg_irq_width;
   logic [ADDR_W-1:0]        pc;
   logic [NUM_SRC-1:0]       irq_ack;
   logic                     cpu_rst_L;
   logic [NUM_SRC-1:0]       irq_L;
   logic                     running;
   logic                     done;
   logic                     timeout;
   logic [NUM_SRC-1:0]       irq_missed;
   logic [CNT_W-1:0]         cycle_count;

   z80_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_SRC(NUM_SRC)) dut (
      .clk            (clk),
      .rst_L          (rst_L),
      .start          (start),
      .cfg_rst_cycles (cfg_rst_cycles),
      .cfg_pc_limit   (cfg_pc_limit),
      .cfg_timeout    (cfg_timeout),
      .cfg_irq_en     (cfg_irq_en),
      .cfg_irq_mode   (cfg_irq_mode),
      .cfg_irq_period (cfg_irq_period),
      .cfg_irq_width  (cfg_irq_width),
      .pc             (pc),
      .irq_ack        (irq_ack),
      .cpu_rst_L      (cpu_rst_L),
      .irq_L          (irq_L),
      .running        (running),
      .done           (done),
      .timeout        (timeout),
      .irq_missed     (irq_missed),
      .cycle_count    (cycle_count)
   );

   typedef struct {
      int unsigned cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned edge_n        = 0;
   int unsigned e_run         = 0;
   int          vectors       = 0;
   int          miscompares   = 0;
   logic        drain_expired = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Insert keeping the queue sorted by edge
   task automatic push(input int unsigned cyc, input int sig, input logic [31:0] val,
                       input string name);
      exp_t e;
      int   idx;
      e.cyc  = cyc;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      idx = sb_q.size();
      while (idx > 0 && sb_q[idx-1].cyc > cyc) idx--;
      sb_q.insert(idx, e);
   endtask

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         SIG_CPU_RST: return 32'(cpu_rst_L);
         SIG_RUNNING: return 32'(running);
         SIG_DONE:    return 32'(done);
         SIG_TIMEOUT: return 32'(timeout);
         SIG_IRQ0:    return 32'(irq_L[0]);
         SIG_IRQ1:    return 32'(irq_L[1]);
         SIG_MISSED:  return 32'(irq_missed);
         SIG_CYCLE:   return 32'(cycle_count);
         default:     return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare everything due at this edge
   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() > 0 && (sb_q[0].cyc <= edge_n || drain_expired)) begin
         e = sb_q.pop_front();
         vectors++;
         if (e.cyc != edge_n) begin
            miscompares++;
            $display("FAIL %s: due at edge %0d, not compared (now edge %0d)",
                     e.name, e.cyc, edge_n);
         end else if (actual(e.sig) !== e.val) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got 0x%0h, want 0x%0h",
                     e.name, edge_n, actual(e.sig), e.val);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int unsigned c);
      while (edge_n < c) tick(1);
   endtask

   // Pulse start; sets e_run to the edge at which RUN is entered
   task automatic launch(input logic [7:0] r, input string tag);
      int unsigned rr;
      rr = (r == 8'd0) ? 1 : int'(r);
      cfg_rst_cycles = r;
      start = 1'b1;
      e_run = edge_n + 1 + rr;
      push(edge_n + 1, SIG_CPU_RST, 0, {tag, "_rst_low"});
      push(edge_n + 1, SIG_DONE,    0, {tag, "_done_clr"});
      push(edge_n + 1, SIG_TIMEOUT, 0, {tag, "_tmo_clr"});
      push(edge_n + 1, SIG_MISSED,  0, {tag, "_miss_clr"});
      push(edge_n + 1, SIG_CYCLE,   0, {tag, "_cyc_clr"});
      push(e_run - 1,  SIG_RUNNING, 0, {tag, "_not_run_yet"});
      push(e_run,      SIG_CPU_RST, 1, {tag, "_rst_rise"});
      push(e_run,      SIG_RUNNING, 1, {tag, "_running"});
      push(e_run,      SIG_CYCLE,   0, {tag, "_cyc_entry"});
      push(e_run + 1,  SIG_CYCLE,   1, {tag, "_cyc_first"});
      tick(1);
      start = 1'b0;
   endtask

   task automatic end_run(input string tag);
      cfg_pc_limit = 16'h0000;
      pc = 16'h0001;
      push(edge_n + 1, SIG_DONE, 1, {tag, "_end_done"});
      push(edge_n + 1, SIG_IRQ0, 1, {tag, "_end_irq0"});
      push(edge_n + 1, SIG_IRQ1, 1, {tag, "_end_irq1"});
      tick(2);
      pc = 16'h0000;
      cfg_irq_en = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned m;
      int unsigned k;
      rst_L = 1'b0; start = 1'b0; cfg_rst_cycles = 8'd0; cfg_pc_limit = 16'h0050;
      cfg_timeout = '0; cfg_irq_en = '0; cfg_irq_mode = '0; cfg_irq_period = '0;
      cfg_irq_width = '0; pc = '0; irq_ack = '0;

      // Reset values
      tick(2);
      push(edge_n, SIG_CPU_RST, 0, "rst_cpu_rst");
      push(edge_n, SIG_RUNNING, 0, "rst_running");
      push(edge_n, SIG_DONE,    0, "rst_done");
      push(edge_n, SIG_TIMEOUT, 0, "rst_timeout");
      push(edge_n, SIG_IRQ0,    1, "rst_irq0");
      push(edge_n, SIG_IRQ1,    1, "rst_irq1");
      push(edge_n, SIG_MISSED,  0, "rst_missed");
      push(edge_n, SIG_CYCLE,   0, "rst_cycle");
      rst_L = 1'b1;
      tick(2);
      push(edge_n, SIG_CPU_RST, 0, "idle_cpu_rst");
      push(edge_n, SIG_RUNNING, 0, "idle_running");

      // S1: reset sequence and pc limit exit
      launch(8'd3, "s1");
      wait_until(e_run + 8);
      pc = 16'h0050;
      push(edge_n + 1, SIG_DONE,    0, "s1_pc_eq_limit");
      push(edge_n + 1, SIG_RUNNING, 1, "s1_pc_eq_running");
      tick(1);
      pc = 16'h0051;
      m = edge_n;
      push(m + 1, SIG_DONE,    1, "s1_done");
      push(m + 1, SIG_RUNNING, 0, "s1_running_off");
      push(m + 1, SIG_CPU_RST, 0, "s1_cpu_frozen");
      push(m + 1, SIG_TIMEOUT, 0, "s1_timeout");
      push(m + 1, SIG_CYCLE,   m + 1 - e_run, "s1_cycle");
      push(m + 4, SIG_DONE,    1, "s1_done_hold");
      push(m + 4, SIG_CYCLE,   m + 1 - e_run, "s1_cycle_hold");
      tick(5);
      pc = 16'h0000;

      // S2: pulse channel 0, period 100 width 10
      cfg_pc_limit = 16'hFFFF;
      cfg_irq_en = 2'b01; cfg_irq_mode = 2'b00;
      cfg_irq_period = {32'd0, 32'd100};
      cfg_irq_width  = {8'd0, 8'd10};
      launch(8'd0, "s2");
      push(e_run + 99,  SIG_IRQ0, 1, "s2_pre_fall");
      push(e_run + 100, SIG_IRQ0, 0, "s2_fall1");
      push(e_run + 109, SIG_IRQ0, 0, "s2_low_last1");
      push(e_run + 110, SIG_IRQ0, 1, "s2_rise1");
      push(e_run + 199, SIG_IRQ0, 1, "s2_pre_fall2");
      push(e_run + 200, SIG_IRQ0, 0, "s2_fall2");
      push(e_run + 209, SIG_IRQ0, 0, "s2_low_last2");
      push(e_run + 210, SIG_IRQ0, 1, "s2_rise2");
      push(e_run + 210, SIG_MISSED, 0, "s2_missed");
      push(e_run + 210, SIG_IRQ1, 1, "s2_irq1_idle");
      wait_until(e_run + 212);
      end_run("s2");

      // S3: hold channel 1 with miss/ack/disable; width-0 pulse on channel 0
      cfg_pc_limit = 16'hFFFF;
      cfg_irq_en = 2'b11; cfg_irq_mode = 2'b10;
      cfg_irq_period = {32'd20, 32'd7};
      cfg_irq_width  = {8'd0, 8'd0};
      launch(8'd2, "s3");
      push(e_run + 6,   SIG_IRQ0, 1, "s3_w0_pre");
      push(e_run + 7,   SIG_IRQ0, 0, "s3_w0_fall");
      push(e_run + 8,   SIG_IRQ0, 1, "s3_w0_rise");
      push(e_run + 14,  SIG_IRQ0, 0, "s3_w0_fall2");
      push(e_run + 15,  SIG_IRQ0, 1, "s3_w0_rise2");
      push(e_run + 19,  SIG_IRQ1, 1, "s3_hold_pre");
      push(e_run + 20,  SIG_IRQ1, 0, "s3_hold_fall");
      push(e_run + 39,  SIG_MISSED, 0, "s3_no_miss_yet");
      push(e_run + 40,  SIG_MISSED, 2, "s3_miss_set");
      push(e_run + 70,  SIG_IRQ1, 0, "s3_hold_still");
      push(e_run + 71,  SIG_IRQ1, 1, "s3_ack_release");
      push(e_run + 79,  SIG_IRQ1, 1, "s3_ack_ignored");
      push(e_run + 80,  SIG_IRQ1, 0, "s3_refire");
      push(e_run + 80,  SIG_MISSED, 2, "s3_miss_sticky");
      push(e_run + 85,  SIG_IRQ1, 0, "s3_pre_disable");
      push(e_run + 86,  SIG_IRQ1, 1, "s3_disable_rel");
      push(e_run + 100, SIG_IRQ1, 1, "s3_disabled");
      wait_until(e_run + 70);
      irq_ack = 2'b10;
      tick(1);
      irq_ack = 2'b00;
      wait_until(e_run + 75);
      irq_ack = 2'b10;
      tick(1);
      irq_ack = 2'b00;
      wait_until(e_run + 85);
      cfg_irq_en = 2'b01;
      wait_until(e_run + 101);
      end_run("s3");

      // S4: timeout exit, 1000 cycles
      cfg_pc_limit = 16'h0050; pc = 16'h0000; cfg_irq_en = '0;
      cfg_timeout = 32'd1000;
      launch(8'd3, "s4");
      push(e_run + 999,  SIG_DONE,    0,    "s4_pre_done");
      push(e_run + 999,  SIG_CYCLE,   999,  "s4_pre_cycle");
      push(e_run + 1000, SIG_DONE,    1,    "s4_done");
      push(e_run + 1000, SIG_TIMEOUT, 1,    "s4_timeout");
      push(e_run + 1000, SIG_CYCLE,   1000, "s4_cycle");
      push(e_run + 1000, SIG_RUNNING, 0,    "s4_running_off");
      push(e_run + 1003, SIG_TIMEOUT, 1,    "s4_timeout_hold");
      wait_until(e_run + 1004);

      // S5: pc and timeout on the same cycle, pc wins
      cfg_timeout = 32'd20;
      launch(8'd1, "s5");
      wait_until(e_run + 19);
      pc = 16'h0051;
      push(e_run + 19, SIG_DONE,    0,  "s5_pre_done");
      push(e_run + 20, SIG_DONE,    1,  "s5_done");
      push(e_run + 20, SIG_TIMEOUT, 0,  "s5_pc_priority");
      push(e_run + 20, SIG_CYCLE,   20, "s5_cycle");
      tick(3);
      pc = 16'h0000;

      // S6: asynchronous reset during an active pulse
      cfg_timeout = '0; cfg_pc_limit = 16'hFFFF;
      cfg_irq_en = 2'b01; cfg_irq_mode = 2'b00;
      cfg_irq_period = {32'd0, 32'd10};
      cfg_irq_width  = {8'd0, 8'd5};
      launch(8'd2, "s6");
      push(e_run + 11, SIG_IRQ0,  0,  "s6_pulse_active");
      push(e_run + 11, SIG_CYCLE, 11, "s6_cycle_before");
      wait_until(e_run + 12);
      rst_L = 1'b0;
      k = edge_n;
      push(k, SIG_CPU_RST, 0, "s6_abort_cpu_rst");
      push(k, SIG_RUNNING, 0, "s6_abort_running");
      push(k, SIG_IRQ0,    1, "s6_abort_irq0");
      push(k, SIG_CYCLE,   0, "s6_abort_cycle");
      push(k, SIG_DONE,    0, "s6_abort_done");
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      rst_L = 1'b1;
      k = edge_n;
      push(k + 3, SIG_CPU_RST, 0, "s6_no_stale_start");
      push(k + 3, SIG_RUNNING, 0, "s6_still_idle");
      wait_until(k + 4);
      launch(8'd2, "s6b");
      push(e_run + 5,  SIG_CYCLE, 5, "s6b_cycle");
      push(e_run + 9,  SIG_IRQ0,  1, "s6b_pre_fall");
      push(e_run + 10, SIG_IRQ0,  0, "s6b_fall");
      push(e_run + 15, SIG_IRQ0,  1, "s6b_rise");
      wait_until(e_run + 16);
      end_run("s6b");

      // Drain the scoreboard with a bound
      for (int i = 0; i < 100 && sb_q.size() > 0; i++) tick(1);
      if (sb_q.size() > 0) begin
         drain_expired = 1'b1;
         @(negedge clk);
         #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
